// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, keeps one imem request in flight, and queues words for decode.
// The optional alignment check (misalign_fault port, HALT state) is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] initial_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign_fault
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DRAIN = 2'd2, S_HALT = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DRAIN = 2'd2} state_e;
`endif

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     pend_pc_q, pend_pc_d;
    logic            req_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     data_d [DEPTH];
    logic [31:0]     pcs_q  [DEPTH];
    logic [31:0]     pcs_d  [DEPTH];

    logic            pop_s;
    logic            push_s;
    logic            flush_s;
    logic [CW-1:0]   cnt_pop_s;
    logic [31:0]     redir_pc_s;

`ifdef FETCH_ALIGN_CHECK_EN
    logic            fault_q, fault_d;
    logic            halt_pend_q, halt_pend_d;
    logic            bad_s;

    assign bad_s          = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign misalign_fault = fault_q;
`endif

    assign pop_s      = valid_q[0] & instr_ready;
    assign cnt_pop_s  = cnt_q - CW'(pop_s);
    assign redir_pc_s = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = valid_q[0];
    assign instr       = data_q[0];
    assign instr_pc    = pcs_q[0];

    // Fetch control: PC sequencing, redirect handling and request lifetime.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        push_s     = 1'b0;
        flush_s    = redirect_valid;
        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc_s;
                    state_d    = S_REQ;
                end else if (cnt_pop_s < DEPTH_C) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        fetch_pc_d = redir_pc_s;
                        state_d    = S_REQ;
                    end else begin
                        // Old request still in flight: park the new PC until its ack drains.
                        pend_pc_d = redir_pc_s;
                        state_d   = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    push_s     = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ((cnt_pop_s + CW'(1)) < DEPTH_C) ? S_REQ : S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    fetch_pc_d = redirect_valid ? redir_pc_s : pend_pc_q;
                    state_d    = S_REQ;
                end else begin
                    pend_pc_d = redirect_valid ? redir_pc_s : pend_pc_q;
                    state_d   = S_DRAIN;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            S_HALT: begin
                state_d = S_HALT;
                flush_s = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        halt_pend_d = halt_pend_q | bad_s;
        fault_d     = fault_q | bad_s;
        state_d     = (halt_pend_d && (state_d != S_DRAIN)) ? S_HALT : state_d;
`endif
    end

    // Shift-register FIFO: entry 0 is the head so the decode outputs come straight from flops.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pcs_d   = pcs_q;
        cnt_d   = cnt_q;
        if (flush_s) begin
            valid_d = '0;
            cnt_d   = '0;
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                valid_d[i] = pop_s ? valid_q[i + 1] : valid_q[i];
                data_d[i]  = pop_s ? data_q[i + 1]  : data_q[i];
                pcs_d[i]   = pop_s ? pcs_q[i + 1]   : pcs_q[i];
            end
            valid_d[DEPTH-1] = pop_s ? 1'b0 : valid_q[DEPTH-1];
            for (int i = 0; i < DEPTH; i++) begin
                valid_d[i] = (push_s && (CW'(i) == cnt_pop_s)) ? 1'b1       : valid_d[i];
                data_d[i]  = (push_s && (CW'(i) == cnt_pop_s)) ? imem_rdata : data_d[i];
                pcs_d[i]   = (push_s && (CW'(i) == cnt_pop_s)) ? fetch_pc_q : pcs_d[i];
            end
            cnt_d = cnt_pop_s + CW'(push_s);
        end
    end

    // State, PC and FIFO registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= initial_pc;
            pend_pc_q  <= 32'd0;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            valid_q    <= '0;
            data_q     <= '{default: 32'd0};
            pcs_q      <= '{default: 32'd0};
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q     <= 1'b0;
            halt_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            req_q      <= (state_d == S_REQ) || (state_d == S_DRAIN);
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            pcs_q      <= pcs_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q     <= fault_d;
            halt_pend_q <= halt_pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table, reset/wrap sequences and a randomized run
// checked against a PC-stream reference model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, redirect_valid, imem_req, imem_ack, instr_valid, instr_ready;
    logic [31:0] initial_pc, redirect_pc, imem_addr, imem_rdata, instr, instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_fault;
`endif
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        ack, rdy, rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_unit #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .initial_pc(initial_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
`ifdef FETCH_ALIGN_CHECK_EN
        , .misalign_fault(misalign_fault)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ack, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.ack = ack; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_pc, busy_addr;
        logic        busy, redir_prev;
        int          lat, waited, delivered;
        logic [31:0] wrap_pc [6];
        logic        wrap_v  [6];

        reset = 1'b1; initial_pc = 32'h0000_1000; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_ack = 1'b0; instr_ready = 1'b0;
        step(); step();
        check("rst_req",   {31'd0, imem_req},    32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr,                32'd0);
        check("rst_pc",    instr_pc,             32'd0);
        check("rst_addr",  imem_addr,            32'h0000_1000);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_fault", {31'd0, misalign_fault}, 32'd0);
`endif

        // ack rdy rv rpc | req addr valid pc
        add(0,1,0,0,            0,32'h1000,0,0);
        add(1,1,0,0,            1,32'h1000,0,0);
        add(1,1,0,0,            1,32'h1004,1,32'h1000);
        add(1,1,0,0,            1,32'h1008,1,32'h1004);
        add(1,0,0,0,            1,32'h100C,1,32'h1008);
        add(0,0,0,0,            0,32'h1010,1,32'h1008);
        add(0,0,0,0,            0,32'h1010,1,32'h1008);
        add(0,1,0,0,            0,32'h1010,1,32'h1008);
        add(0,0,0,0,            1,32'h1010,1,32'h100C);
        add(1,0,0,0,            1,32'h1010,1,32'h100C);
        add(0,1,0,0,            0,32'h1014,1,32'h100C);
        add(0,1,0,0,            1,32'h1014,1,32'h1010);
        add(1,0,0,0,            1,32'h1014,0,0);
        add(1,0,1,32'h300,      1,32'h1018,1,32'h1014);
        add(0,1,0,0,            1,32'h0300,0,0);
        add(1,1,0,0,            1,32'h0300,0,0);
        add(0,1,0,0,            1,32'h0304,1,32'h0300);
        add(0,1,0,0,            1,32'h0304,0,0);
        add(0,1,1,32'h200,      1,32'h0304,0,0);
        add(1,1,0,0,            1,32'h0304,0,0);
        add(1,1,0,0,            1,32'h0200,0,0);
        add(0,1,0,0,            1,32'h0204,1,32'h0200);
        add(1,0,0,0,            1,32'h0204,0,0);
        add(1,0,0,0,            1,32'h0208,1,32'h0204);
        add(0,0,1,32'h400,      0,32'h020C,1,32'h0204);
        add(0,0,0,0,            1,32'h0400,0,0);
        add(1,1,0,0,            1,32'h0400,0,0);
        add(0,1,0,0,            1,32'h0404,1,32'h0400);

        reset = 1'b0;
        for (int r = 0; r < vecs.size(); r++) begin
            imem_ack = vecs[r].ack; instr_ready = vecs[r].rdy;
            redirect_valid = vecs[r].rv; redirect_pc = vecs[r].rpc;
            check($sformatf("row%0d_req", r),   {31'd0, imem_req},    {31'd0, vecs[r].e_req});
            check($sformatf("row%0d_addr", r),  imem_addr,            vecs[r].e_addr);
            check($sformatf("row%0d_valid", r), {31'd0, instr_valid}, {31'd0, vecs[r].e_valid});
            if (vecs[r].e_valid) begin
                check($sformatf("row%0d_pc", r),    instr_pc, vecs[r].e_pc);
                check($sformatf("row%0d_instr", r), instr,    mem_word(vecs[r].e_pc));
            end
            step();
        end

        // Address wrap with zero-wait memory: first delivery two cycles after reset release.
        wrap_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        wrap_pc = '{32'd0, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        redirect_valid = 1'b0; reset = 1'b1; initial_pc = 32'hFFFF_FFF8; imem_ack = 1'b1; instr_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check($sformatf("wrap%0d_valid", c), {31'd0, instr_valid}, {31'd0, wrap_v[c]});
            if (wrap_v[c]) check($sformatf("wrap%0d_pc", c), instr_pc, wrap_pc[c]);
            step();
        end

        // Reset while a request is outstanding; a late ack must be ignored.
        imem_ack = 1'b0;
        step();
        reset = 1'b1; initial_pc = 32'h0000_2000;
        step();
        check("midrst_req_drop", {31'd0, imem_req}, 32'd0);
        reset = 1'b0; imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("midrst_req",   {31'd0, imem_req},    32'd1);
        check("midrst_addr",  imem_addr,            32'h0000_2000);
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check("midrst_valid2", {31'd0, instr_valid}, 32'd0);

        // Randomized run: latency 0..3, random ready, random redirects.
        reset = 1'b1; initial_pc = $urandom() & 32'hFFFF_FFFC; imem_ack = 1'b0; instr_ready = 1'b0;
        step(); step();
        reset = 1'b0; exp_pc = initial_pc; busy = 1'b0; redir_prev = 1'b0; delivered = 0;
        lat = 0; waited = 0; busy_addr = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            imem_ack = 1'b0;
            if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1; busy_addr = imem_addr; lat = $urandom_range(0, 3); waited = 0;
                end else begin
                    check("rnd_addr_stable", imem_addr, busy_addr);
                end
                if (waited == lat) begin
                    imem_ack = 1'b1; busy = 1'b0;
                end else begin
                    waited++;
                end
            end else if (busy) begin
                check("rnd_req_held", {31'd0, imem_req}, 32'd1);
                busy = 1'b0;
            end
            redirect_valid = ($urandom_range(0, 15) == 0);
`ifdef FETCH_ALIGN_CHECK_EN
            redirect_pc = $urandom() & 32'hFFFF_FFFC;
`else
            redirect_pc = $urandom();
`endif
            instr_ready = redirect_valid ? 1'b0 : 1'($urandom_range(0, 1));
            if (redir_prev) check("rnd_flush", {31'd0, instr_valid}, 32'd0);
            if (instr_valid && instr_ready) begin
                check("rnd_pc", instr_pc, exp_pc);
                check("rnd_instr", instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            redir_prev = redirect_valid;
            step();
        end
        redirect_valid = 1'b0; instr_ready = 1'b0; imem_ack = 1'b0;
        check("rnd_liveness", {31'd0, delivered > 300}, 32'd1);

`ifdef FETCH_ALIGN_CHECK_EN
        reset = 1'b1; initial_pc = 32'h0000_1000; imem_ack = 1'b1; instr_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        step(); step(); step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("halt_fault", {31'd0, misalign_fault}, 32'd1);
            check("halt_req",   {31'd0, imem_req},       32'd0);
            check("halt_valid", {31'd0, instr_valid},    32'd0);
            step();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
